// File: rtl/secp256k1_pkg.sv
// Shared constants and types for the secp256k1 modular-inverse arbiter.
// Holds the field prime, operand width and arbiter state encoding.
package secp256k1_pkg;

   localparam int unsigned W = 256;

   localparam logic [W-1:0] P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      RESPOND
   } arb_state_t;

endpackage

// File: rtl/mod_inv_arb_if.sv
// Requester-side request/response bundle of the modular-inverse arbiter.
// master = requesters, slave = arbiter.
interface mod_inv_arb_if #(
   parameter int NUM_REQ = 2
);
   import secp256k1_pkg::*;

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*W-1:0] req_operand;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   resp_valid;
   logic [W-1:0]         resp_result;
   logic                 resp_err;

   modport master (
      output req_valid,
      output req_operand,
      input  req_ready,
      input  resp_valid,
      input  resp_result,
      input  resp_err
   );

   modport slave (
      input  req_valid,
      input  req_operand,
      output req_ready,
      output resp_valid,
      output resp_result,
      output resp_err
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted request at or after ptr wins.
// Pure combinational; grant is one-hot or zero.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!found && req[j] && j == (int'(ptr) + k) % N) begin
               grant[j] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mod_inv_arb.sv
// Arbitrates NUM_REQ requesters onto one secp256k1 modular-inverse unit.
// Optional watchdog on the inverse unit: define MOD_INV_ARB_TIMEOUT_EN.
module mod_inv_arb
   import secp256k1_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         reset,
   mod_inv_arb_if.slave bus,
   output logic         inv_start,
   output logic [W-1:0] inv_operand,
   input  logic         inv_done,
   input  logic [W-1:0] inv_result,
   output logic         busy
);

   localparam int PW = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   arb_state_t state, state_n;

   logic [PW-1:0]      ptr;
   logic [PW-1:0]      idx;
   logic [PW-1:0]      grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic [W-1:0]       sel_op;
   logic [W-1:0]       op_q;
   logic [W-1:0]       res_q;
   logic               err_q;
   logic               accept;
   logic               op_ok;
   logic               timeout;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   always_comb begin
      sel_op    = '0;
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_op    = bus.req_operand[i*W +: W];
            grant_idx = PW'(i);
         end
      end
   end

   assign op_ok         = (sel_op != '0) && (sel_op < P);
   assign bus.req_ready = (state == IDLE && !reset) ? grant : '0;
   assign accept        = |bus.req_ready;

   always_comb begin
      state_n = state;
      unique case (1'b1)
         state == IDLE:
            if (accept) state_n = op_ok ? ISSUE : RESPOND;
         state == ISSUE:
            state_n = WAIT_DONE;
         state == WAIT_DONE:
            if (inv_done || timeout) state_n = RESPOND;
         state == RESPOND:
            state_n = IDLE;
         default:
            state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         idx   <= '0;
         op_q  <= '0;
         res_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            idx  <= grant_idx;
            op_q <= sel_op;
            ptr  <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if (!op_ok) begin
               res_q <= '0;
               err_q <= 1'b1;
            end
         end
         // a completion in the same cycle as the watchdog still wins
         if (state == WAIT_DONE) begin
            if (inv_done) begin
               res_q <= inv_result;
               err_q <= 1'b0;
            end else if (timeout) begin
               res_q <= '0;
               err_q <= 1'b1;
            end
         end
      end
   end

`ifdef MOD_INV_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (reset || state != WAIT_DONE) to_cnt <= '0;
      else                             to_cnt <= to_cnt + 1'b1;
   end

   assign timeout = (state == WAIT_DONE) && (to_cnt == CW'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   assign inv_start       = (state == ISSUE);
   assign inv_operand     = op_q;
   assign busy            = (state != IDLE);
   assign bus.resp_valid  = (state == RESPOND) ? (ONE << idx) : '0;
   assign bus.resp_result = res_q;
   assign bus.resp_err    = err_q;

   param_ok_a: assert property (@(posedge clk)
      NUM_REQ >= 2 && NUM_REQ <= 8 && TIMEOUT >= 1);

endmodule

// File: tb/tb_mod_inv_arb.sv
// Scoreboard bench for mod_inv_arb with a behavioural inverse-unit model.
// Expected inverses come from Fermat exponentiation a^(P-2) mod P.
module tb_mod_inv_arb;
   import secp256k1_pkg::*;

   localparam int NR = 2;
   localparam int TO = 16;
   localparam logic [255:0] INV2 =
      256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         inv_start;
   logic [255:0] inv_operand;
   logic         inv_done = 1'b0;
   logic [255:0] inv_result = '0;
   logic         busy;

   mod_inv_arb_if #(.NUM_REQ(NR)) bus ();

   mod_inv_arb #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .inv_start   (inv_start),
      .inv_operand (inv_operand),
      .inv_done    (inv_done),
      .inv_result  (inv_result),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           idx;
      logic [255:0] res;
      bit           err;
      int           kind;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   grants[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_acc = -10;
   int   exp_start = -10;
   int   free_cyc = 0;
   int   last_done = -10;
   int   rr_ptr = 0;
   int   resp_seen = 0;
   int   exp_total = 0;
   int   gen_en = 0;
   bit   chk_en = 0;
   bit   resp_en = 1;
   bit   to_mode = 0;
   logic [255:0] exp_op = '0;
   bit           pend [NR];
   logic [255:0] pop  [NR];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [255:0] mulmod(logic [255:0] a, logic [255:0] b);
      logic [511:0] t;
      t = {256'b0, a} * {256'b0, b};
      t = t % {256'b0, P};
      return t[255:0];
   endfunction

   function automatic logic [255:0] modinv(logic [255:0] a);
      logic [255:0] e, r, b;
      e = P - 256'd2;
      r = 256'd1;
      b = a;
      for (int i = 0; i < 256; i++) begin
         if (e[i]) r = mulmod(r, b);
         b = mulmod(b, b);
      end
      return r;
   endfunction

   function automatic logic [255:0] rand_op();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return P;
         2:       return P + 256'($urandom_range(1, 50));
         3:       return 256'($urandom_range(1, 9));
         4:       return P - 256'd1;
         default: return r;
      endcase
   endfunction

   task automatic drive_reqs();
      logic [NR-1:0]     v;
      logic [NR*256-1:0] o;
      for (int i = 0; i < NR; i++) begin
         v[i]           = pend[i];
         o[i*256 +: 256] = pop[i];
      end
      bus.req_valid   = v;
      bus.req_operand = o;
   endtask

   task automatic accept(int w);
      exp_t         e;
      logic [255:0] op;
      bit           ok;
      op = pop[w];
      ok = (op != '0) && (op < P);
      last_acc = cyc;
      free_cyc = 1 << 30;
      grants.push_back(w);
      rr_ptr  = (w + 1) % NR;
      pend[w] = 0;
      e.idx = w;
      e.acc = cyc;
      if (!ok) begin
         e.res = '0; e.err = 1; e.kind = 0;
      end else begin
         exp_start = cyc + 1;
         exp_op    = op;
         if (to_mode) begin
            e.res = '0; e.err = 1; e.kind = 2;
         end else begin
            e.res = (op == 256'd2) ? INV2 : modinv(op);
            e.err = 0; e.kind = 1;
         end
      end
      q.push_back(e);
      exp_total++;
   endtask

   task automatic run(int n);
      for (int t = 0; t < n; t++) begin
         logic [NR-1:0] er;
         int            w;
         @(negedge clk);
         er = '0;
         w  = -1;
         if (cyc >= free_cyc) begin
            for (int k = 0; k < NR; k++) begin
               int j;
               j = (rr_ptr + k) % NR;
               if (w < 0 && bus.req_valid[j]) w = j;
            end
         end
         if (w >= 0) er[w] = 1'b1;
         chk("req_ready", 256'(bus.req_ready), 256'(er));
         if (w >= 0) accept(w);
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && gen_en == 1 && $urandom_range(0, 2) != 0) begin
               pend[i] = 1; pop[i] = rand_op();
            end else if (!pend[i] && gen_en == 2) begin
               pend[i] = 1; pop[i] = 256'($urandom_range(1, 1000));
            end
         end
         drive_reqs();
      end
   endtask

   task automatic drain(int maxc);
      int  n;
      bit  busy_m;
      n = 0;
      busy_m = 1;
      while (busy_m && n < maxc) begin
         busy_m = (q.size() != 0) || (cyc < free_cyc);
         for (int i = 0; i < NR; i++) busy_m = busy_m || pend[i];
         if (busy_m) begin
            run(1);
            n++;
         end
      end
      total++;
      if (busy_m) begin
         bad++;
         $display("FAIL drain: %0d responses outstanding after %0d cycles", q.size(), maxc);
      end
      run(2);
   endtask

   task automatic do_reset(int n);
      chk_en = 0;
      reset  = 1'b1;
      @(posedge clk);
      repeat (n) begin
         @(negedge clk);
         chk("rst_req_ready", 256'(bus.req_ready), '0);
         chk("rst_resp_valid", 256'(bus.resp_valid), '0);
         chk("rst_resp_result", bus.resp_result, '0);
         chk("rst_resp_err", 256'(bus.resp_err), '0);
         chk("rst_inv_start", 256'(inv_start), '0);
         chk("rst_inv_operand", inv_operand, '0);
         chk("rst_busy", 256'(busy), '0);
      end
      exp_total -= q.size();
      q.delete();
      @(posedge clk);
      #1;
      reset     = 1'b0;
      rr_ptr    = 0;
      free_cyc  = 0;
      last_acc  = -10;
      exp_start = -10;
      chk_en    = 1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("inv_start", 256'(inv_start), 256'(cyc == exp_start));
         if (inv_start) chk("inv_operand", inv_operand, exp_op);
         chk("busy", 256'(busy), 256'(cyc > last_acc && cyc < free_cyc));
      end
   end

   always @(negedge clk) begin
      exp_t          e;
      int            ec;
      logic [NR-1:0] oh;
      if (bus.resp_valid != '0) begin
         resp_seen++;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got resp_valid=%b want none (cycle %0d)",
                     bus.resp_valid, cyc);
         end else begin
            e  = q.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            case (e.kind)
               0:       ec = e.acc + 1;
               1:       ec = last_done + 1;
               default: ec = e.acc + 2 + TO;
            endcase
            chk("resp_valid", 256'(bus.resp_valid), 256'(oh));
            chk("resp_result", bus.resp_result, e.res);
            chk("resp_err", 256'(bus.resp_err), 256'(e.err));
            chk("resp_cycle", 256'(cyc), 256'(ec));
            free_cyc = cyc + 1;
         end
      end
   end

   always begin
      logic [255:0] op;
      int           d;
      @(negedge clk);
      if (chk_en && resp_en && inv_start === 1'b1) begin
         op = inv_operand;
         d  = $urandom_range(1, 4);
         repeat (d) @(negedge clk);
         inv_result = modinv(op);
         inv_done   = 1'b1;
         last_done  = cyc;
         @(negedge clk);
         inv_done   = 1'b0;
         inv_result = {8{$urandom}};
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      pend[0] = 1; pop[0] = 256'd5;
      pend[1] = 1; pop[1] = 256'd7;
      drive_reqs();
      do_reset(3);

      // both requesters held valid: grants must alternate
      gen_en = 2;
      for (int n = 0; n < 200 && grants.size() < 4; n++) run(1);
      gen_en = 0;
      for (int k = 0; k < 4; k++) begin
         int g;
         g = (k < grants.size()) ? grants[k] : -1;
         chk("grant_order", 256'(g), 256'(k % 2));
      end
      drain(100);

      pend[0] = 1; pop[0] = 256'd2;
      drive_reqs();
      drain(50);

      pend[1] = 1; pop[1] = '0;
      drive_reqs();
      drain(20);
      pend[0] = 1; pop[0] = P;
      drive_reqs();
      drain(20);

      @(negedge clk);
      inv_done = 1'b1;
      inv_result = {8{$urandom}};
      @(negedge clk);
      inv_done = 1'b0;
      run(4);
      chk("idle_done_ignored", 256'(resp_seen), 256'(exp_total));

      gen_en = 1;
      run(300);
      gen_en = 0;
      drain(200);
      chk("resp_count", 256'(resp_seen), 256'(exp_total));

      resp_en = 0;
      pend[1] = 1; pop[1] = 256'd11;
      drive_reqs();
      run(4);
      do_reset(2);
      resp_en = 1;
      pend[0] = 1; pop[0] = 256'd3;
      drive_reqs();
      drain(50);
      chk("post_reset_count", 256'(resp_seen), 256'(exp_total));

`ifdef MOD_INV_ARB_TIMEOUT_EN
      to_mode = 1;
      resp_en = 0;
      pend[0] = 1; pop[0] = 256'd4;
      drive_reqs();
      drain(60);
      @(negedge clk);
      inv_done = 1'b1;
      @(negedge clk);
      inv_done = 1'b0;
      run(4);
      chk("late_done_ignored", 256'(resp_seen), 256'(exp_total));
      to_mode = 0;
      resp_en = 1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_inv_arb.md
MOD_INV_ARB -- requirements
Module: mod_inv_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL set the number of requesters sharing one modular-inverse unit (range 2..8).
REQ-002 Parameter TIMEOUT, default 1024, SHALL set the watchdog limit in cycles; it is used only when MOD_INV_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  SHALL flag, per requester, that an operand is offered.
REQ-006 req_operand  input  NUM_REQ*256  SHALL carry the flattened operands; requester i uses bits [256*i+255:256*i].
REQ-007 req_ready  output  NUM_REQ  SHALL flag that the operand is accepted; it is one-hot or zero.
REQ-008 resp_valid  output  NUM_REQ  SHALL pulse one-hot for one cycle when a response is returned.
REQ-009 resp_result  output  256  SHALL carry the inverse, shared by all requesters, and is valid with resp_valid.
REQ-010 resp_err  output  1  SHALL flag an invalid operand or a timeout, and is valid with resp_valid.
REQ-011 inv_start  output  1, inv_operand  output  256 SHALL drive the inverse unit's start and input.
REQ-012 inv_done  input  1, inv_result  input  256 SHALL receive the inverse unit's completion and result.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE and RESPOND.
- IDLE to ISSUE on an accept with a valid operand.
- IDLE to RESPOND on an accept with an invalid operand.
- ISSUE to WAIT_DONE always.
- WAIT_DONE to RESPOND on inv_done, or on timeout.
- RESPOND to IDLE always.
REQ-015 In IDLE, req_ready SHALL be driven combinationally to the round-robin winner among the asserted req_valid bits; accept = req_valid[i] & req_ready[i].
REQ-016 Round-robin: after a grant to requester i, priority SHALL start at i+1 modulo NUM_REQ; the pointer is 0 after reset.
REQ-017 On accept, the block SHALL latch the operand and the requester index; req_ready SHALL be 0 in all non-IDLE states.
REQ-018 An operand equal to 0, or greater than or equal to P, SHALL be invalid: no inv_start is issued, and RESPOND returns result 0 with resp_err=1 in the cycle after accept.
REQ-019 In ISSUE, inv_start SHALL be 1 for exactly one cycle, with inv_operand equal to the latched operand; inv_operand SHALL stay stable until RESPOND.
REQ-020 In WAIT_DONE, inv_result SHALL be captured in the cycle where inv_done=1; resp_valid then pulses in the next cycle with resp_err=0.
REQ-021 Latency: with accept in cycle T and inv_done in cycle D, inv_start SHALL be in T+1, resp_valid in D+1, and the earliest next accept in D+2.
REQ-022 inv_done outside WAIT_DONE SHALL be ignored.
REQ-023 Responses have no backpressure; a requester may re-assert req_valid in the cycle of its own resp_valid.

Reset
REQ-024 Reset SHALL force IDLE, the round-robin pointer to 0, and all outputs to 0, including req_ready, resp_valid, resp_result, resp_err, inv_start, inv_operand and busy.
REQ-025 Reset mid-operation SHALL abandon the transaction with no response; the inverse unit shares the same reset.

Configuration
REQ-026 With MOD_INV_ARB_TIMEOUT_EN defined:
- a cycle counter SHALL clear on entry to WAIT_DONE;
- if it reaches TIMEOUT without inv_done, RESPOND returns result 0 with resp_err=1;
- a later inv_done for that transaction is ignored (REQ-022).
REQ-027 Without MOD_INV_ARB_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely, and no counter logic is generated.

Structure
REQ-028 Package secp256k1_pkg SHALL hold the field prime P (256'hFFFF...FFFEFFFFFC2F), the 256-bit width constant, and the arbiter state typedef.
REQ-029 Round-robin selection SHALL be a separate sub-module, rr_arbiter (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-030 Operand 2 from requester 0 SHALL give inv_start one cycle after accept, then resp_valid=01 with result 7FFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF 7FFFFE18 and resp_err=0.
REQ-031 Both requesters valid continuously after reset SHALL give grant order 0,1,0,1, each grant made only after the previous resp_valid.
REQ-032 Operand 0, and operand P, SHALL each give no inv_start and resp_valid one cycle after accept, with result 0 and resp_err=1.
REQ-033 Reset asserted during WAIT_DONE, followed by a new request, SHALL give no stale response and all outputs 0 during reset; the new request completes normally.
REQ-034 With MOD_INV_ARB_TIMEOUT_EN defined, TIMEOUT=16 and inv_done held at 0, resp_err=1 SHALL occur 16 cycles after WAIT_DONE entry; a late inv_done SHALL be ignored.
REQ-035 An inv_done pulse injected in IDLE SHALL produce no resp_valid.
